mem_stage_access_ctrl: RTL

Memory-stage consumer of the EX/MEM pipeline register outputs in the 5-stage MIPS core.
- Resolves branches and produces PCSrc.
- Drives a multi-cycle data memory over a req/ack handshake and stalls the upstream pipeline while an access is pending.
- Registers results into the MEM/WB stage, inserting bubbles while stalled.

---
 rtl/mem_stage_access_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_access_ctrl
// Brief    : MEM-stage controller. Resolves branches (PCSrc), runs one
//            req/ack data-memory access at a time, stalls the upstream
//            pipeline while an access is in flight, and registers results
//            into MEM/WB (bubbles while stalled).
// Options  : MEM_TIMEOUT_EN - abort an ACCESS after TIMEOUT_CYCLES without
//            ack, return 32'hDEADBEEF as load data and raise sticky mem_err.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_access_ctrl #(
  parameter int DATA_W = 32,
`ifdef MEM_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 16,
`endif
  parameter int REG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  // EX/MEM pipeline register outputs
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              MemWrite_in,
  input  logic              Branch_in,
  input  logic [DATA_W-1:0] BranchTarget_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] WriteData_in,
  input  logic [REG_W-1:0]  WriteReg_in,
  input  logic              Zero_in,
  // data memory handshake
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // pipeline control
  output logic              stall,
  output logic              PCSrc,
  output logic [DATA_W-1:0] BranchTarget_out,
  output logic              misalign,
  // MEM/WB pipeline register
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [DATA_W-1:0] ReadData_out,
  output logic [DATA_W-1:0] ALUResult_out,
`ifdef MEM_TIMEOUT_EN
  output logic              mem_err,
`endif
  output logic [REG_W-1:0]  WriteReg_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                misalign_q, misalign_d;
  logic [DATA_W-1:0]   rdbuf_q, rdbuf_d;
  logic                regwrite_q, regwrite_d;
  logic                memtoreg_q, memtoreg_d;
  logic [DATA_W-1:0]   readdata_q, readdata_d;
  logic [DATA_W-1:0]   aluresult_q, aluresult_d;
  logic [REG_W-1:0]    writereg_q, writereg_d;
  logic                stall_w;

`ifdef MEM_TIMEOUT_EN
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;
  logic                mem_err_q, mem_err_d;
`endif

  logic memop_w;
  logic misaligned_w;

  assign memop_w      = MemtoReg_in | MemWrite_in;
  assign misaligned_w = (ALUResult_in[1:0] != 2'b00);

  // Next-state, memory request and MEM/WB next values; MEM/WB defaults to a bubble.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    misalign_d  = 1'b0;
    rdbuf_d     = rdbuf_q;
    regwrite_d  = 1'b0;
    memtoreg_d  = 1'b0;
    readdata_d  = '0;
    aluresult_d = '0;
    writereg_d  = '0;
    stall_w     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    mem_err_d   = mem_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (memop_w) begin
          if (misaligned_w) begin
            // Misaligned access is dropped: no request, retire as a bubble.
            misalign_d = 1'b1;
          end else begin
            stall_w     = 1'b1;
            state_d     = S_ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWrite_in;
            mem_addr_d  = ALUResult_in;
            mem_wdata_d = WriteData_in;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_d   = 8'd0;
`endif
          end
        end else begin
          regwrite_d  = RegWrite_in;
          memtoreg_d  = MemtoReg_in;
          aluresult_d = ALUResult_in;
          writereg_d  = WriteReg_in;
        end
      end

      S_ACCESS: begin
        stall_w = 1'b1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
          if (!mem_we_q) begin
            rdbuf_d = mem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          // Last permitted ACCESS cycle without ack: abandon the request.
          mem_req_d = 1'b0;
          state_d   = S_DONE;
          rdbuf_d   = DATA_W'(32'hDEADBEEF);
          mem_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
        end
      end

      S_DONE: begin
        // EX/MEM still holds the memop here; retire it into MEM/WB.
        state_d     = S_IDLE;
        regwrite_d  = RegWrite_in;
        memtoreg_d  = MemtoReg_in;
        aluresult_d = ALUResult_in;
        writereg_d  = WriteReg_in;
        readdata_d  = mem_we_q ? '0 : rdbuf_q;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and all registered outputs; synchronous reset drops any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      misalign_q  <= 1'b0;
      rdbuf_q     <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      readdata_q  <= '0;
      aluresult_q <= '0;
      writereg_q  <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
      mem_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      misalign_q  <= misalign_d;
      rdbuf_q     <= rdbuf_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      readdata_q  <= readdata_d;
      aluresult_q <= aluresult_d;
      writereg_q  <= writereg_d;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      mem_err_q   <= mem_err_d;
`endif
    end
  end

  assign stall            = stall_w;
  assign PCSrc            = Branch_in & Zero_in & (state_q == S_IDLE);
  assign BranchTarget_out = BranchTarget_in;
  assign mem_req          = mem_req_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign misalign         = misalign_q;
  assign RegWrite_out     = regwrite_q;
  assign MemtoReg_out     = memtoreg_q;
  assign ReadData_out     = readdata_q;
  assign ALUResult_out    = aluresult_q;
  assign WriteReg_out     = writereg_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_err          = mem_err_q;
`endif

endmodule
`default_nettype wire
